aes_key_schedule: RTL and testbench
===================================

AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

Interface
REQ-001 The block SHALL have the parameter NR, default 10, giving the number of expansion rounds (AES-128).
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have the port key_in, input, 128 bits: cipher key; [127:96] is word w0 and [31:0] is word w3.
REQ-005 The block SHALL have the port key_valid, input, 1 bit: the offered key_in is valid.
REQ-006 The block SHALL have the port key_ready, output, 1 bit: the block can accept a key.
REQ-007 The block SHALL have the port busy, output, 1 bit: expansion is in progress.
REQ-008 The block SHALL have the port done, output, 1 bit: one-cycle pulse when round key NR has been written.
REQ-009 The block SHALL have the port keys_valid, output, 1 bit: all NR+1 stored round keys belong to the last accepted key.
REQ-010 The block SHALL have the port rk_addr, input, 4 bits: round-key read index, 0..NR.
REQ-011 The block SHALL have the port rk_out, output, 128 bits: registered read data.

Function
REQ-012 The block SHALL implement the states IDLE, EXPAND and READY.
REQ-013 key_ready SHALL be 1 in IDLE and READY and 0 in EXPAND; busy SHALL be 1 only in EXPAND.
REQ-014 On a rising edge with key_valid=1 and key_ready=1 (accept edge t0), the block SHALL write key_in to slot 0, set round counter r to 1, set the Rcon register to 8'h01, clear keys_valid and enter EXPAND.
REQ-015 On each EXPAND edge, the block SHALL compute slot[r] from slot[r-1] and Rcon as follows: t = SubWord(RotWord(w3)) ^ {Rcon,24'h0}; w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
REQ-016 On each EXPAND edge, the block SHALL write slot[r], increment r and advance Rcon by xtime (shift left 1; XOR 8'h1B if bit 7 was set), giving 01,02,04,08,10,20,40,80,1B,36.
REQ-017 The edge that writes slot NR (edge t0+NR) SHALL move the block to READY, set keys_valid=1 and set done=1 for exactly the following cycle.
REQ-018 key_valid in EXPAND SHALL be ignored; no restart and no queuing.
REQ-019 Acceptance in READY SHALL behave as in REQ-014: keys_valid drops on the accept edge and the old slots are overwritten progressively.
REQ-020 rk_out SHALL equal slot[rk_addr] one cycle after rk_addr is sampled.
REQ-021 rk_out SHALL be 128'h0 when rk_addr > NR.
REQ-022 A read of a slot in the same edge as its write SHALL return the old contents.
REQ-023 Reads during EXPAND SHALL be permitted; their data is only guaranteed current when keys_valid=1.
REQ-024 No combinational path SHALL exist from any input to any output; all outputs are registered.

Reset
REQ-025 With rst=1 at an edge, the block SHALL set state to IDLE, r to 0, Rcon to 8'h01, done to 0, keys_valid to 0 and rk_out to 0; key_ready then reads 1 and busy reads 0.
REQ-026 Reset SHALL take priority over key acceptance in the same cycle.
REQ-027 A reset during EXPAND SHALL abort expansion with no done pulse.
REQ-028 The key slot storage SHALL need no reset.

Structure
REQ-029 The shared AES package SHALL hold the S-box function or table, the xtime function, the RCON_INIT constant and the state encoding.
REQ-030 The design SHALL use one combinational sub-module, key_expand_step, which takes a 128-bit previous key and 8-bit Rcon and returns the 128-bit next key; the S-box is instanced four times inside it.
REQ-031 The key slots SHALL be an (NR+1)x128 register array or inferred RAM with one write port and one synchronous read port.

Verification
REQ-032 The bench SHALL check that key 2b7e151628aed2a6abf7158809cf4f3c accepted at t0 gives done at t0+NR+1, slot1 = a0fafe1788542cb123a339392a6c7605 and slot10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-033 The bench SHALL check that an all-zero key gives slot1 = 62636363626363636263636362636363 and slot10 = b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-034 The bench SHALL check that key_valid pulsed during EXPAND with a different key leaves the results of REQ-032 unchanged, with key_ready=0 throughout EXPAND.
REQ-035 The bench SHALL check that rst asserted at t0+5 gives IDLE next cycle, no done pulse and keys_valid=0, and that a following re-load completes correctly.
REQ-036 The bench SHALL check that a new key accepted in READY drops keys_valid on the accept edge, that done recurs after NR+1 cycles, and that slot0 returns the new key.
REQ-037 The bench SHALL check that rk_addr = 11 or 15 gives rk_out = 0 on the next cycle.

Source files
------------

// File: rtl/aes_key_schedule_pkg.sv
// Shared AES definitions for the key schedule.
// Contents:
//   RCON_INIT : first round constant
//   state_t   : key schedule controller states
//   xtime     : multiply by x in GF(2^8) (AES polynomial 0x11B)
//   gf_mul    : general GF(2^8) multiply
//   sbox      : AES forward S-box (multiplicative inverse + affine map)
package aes_key_schedule_pkg;

    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        READY
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = '0;
        aa  = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

    // Inverse computed as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0,
    // which the affine step then turns into 0x63 as required.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] inv;
        p   = a;
        inv = 8'h01;
        for (int unsigned i = 0; i < 7; i++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_key_schedule_step.sv
// One AES-128 key expansion round, purely combinational.
// Ports:
//   prev_key : 128-bit round key r-1 ([127:96] = w0 ... [31:0] = w3)
//   rcon     : round constant for this round
//   next_key : 128-bit round key r
module key_expand_step
    import aes_key_schedule_pkg::*;
(
    input  logic [127:0] prev_key,
    input  logic [7:0]   rcon,
    output logic [127:0] next_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    assign w0 = prev_key[127:96];
    assign w1 = prev_key[95:64];
    assign w2 = prev_key[63:32];
    assign w3 = prev_key[31:0];

    // SubWord(RotWord(w3)): rotate left by one byte, then substitute each byte.
    assign t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
             ^ {rcon, 24'h0};

    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_schedule.sv
// AES key schedule: accepts a cipher key, expands it one round per clock
// into NR+1 stored round keys and serves them through a registered read port.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   key_in     : cipher key, [127:96] = w0
//   key_valid  : key_in offered
//   key_ready  : a key can be accepted (IDLE or READY)
//   busy       : expansion in progress
//   done       : one-cycle pulse after round key NR is written
//   keys_valid : all stored round keys belong to the last accepted key
//   rk_addr    : round key read index
//   rk_out     : registered read data, zero for rk_addr > NR
module aes_key_schedule
    import aes_key_schedule_pkg::*;
#(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    input  logic [3:0]   rk_addr,
    output logic [127:0] rk_out
);

    localparam logic [3:0] NR_L = 4'(NR);

    state_t       state_q, state_d;
    logic [3:0]   r_q;
    logic [7:0]   rcon_q;
    logic         done_q;
    logic         keys_valid_q;
    logic [127:0] rk_out_q;

    logic [127:0] slot_mem [0:NR];
    logic [127:0] prev_q;
    logic [127:0] next_key;

    logic accept;
    logic last_round;

    assign key_ready  = (state_q != EXPAND);
    assign busy       = (state_q == EXPAND);
    assign done       = done_q;
    assign keys_valid = keys_valid_q;
    assign rk_out     = rk_out_q;

    assign accept     = key_valid && key_ready && !rst;
    assign last_round = (state_q == EXPAND) && (r_q == NR_L);

    key_expand_step u_step (
        .prev_key (prev_q),
        .rcon     (rcon_q),
        .next_key (next_key)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, READY: if (key_valid) state_d = EXPAND;
            EXPAND:      if (r_q == NR_L) state_d = READY;
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q          <= '0;
            rcon_q       <= RCON_INIT;
            done_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            rk_out_q     <= '0;
        end else begin
            done_q   <= last_round;
            rk_out_q <= (rk_addr > NR_L) ? '0 : slot_mem[rk_addr];
            if (accept) begin
                r_q          <= 4'd1;
                rcon_q       <= RCON_INIT;
                keys_valid_q <= 1'b0;
            end else if (state_q == EXPAND) begin
                r_q    <= r_q + 4'd1;
                rcon_q <= xtime(rcon_q);
                if (last_round) keys_valid_q <= 1'b1;
            end
        end
    end

    // prev_q shadows the most recently written slot so the round logic never
    // needs a second read port on the slot array.
    always_ff @(posedge clk) begin
        if (accept) begin
            slot_mem[0] <= key_in;
            prev_q      <= key_in;
        end else if (state_q == EXPAND && !rst) begin
            slot_mem[r_q] <= next_key;
            prev_q        <= next_key;
        end
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: directed known-answer vectors,
// random keys against a word-level FIPS-197 expansion model, protocol and
// reset behaviour, out-of-range reads.
module tb_aes_key_schedule;

    localparam int NR = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic [3:0]   rk_addr;
    logic [127:0] rk_out;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]   sbox_t [256];
    logic [127:0] exp_rk [NR+1];
    logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    aes_key_schedule #(.NR(NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .rk_addr    (rk_addr),
        .rk_out     (rk_out)
    );

    always #5 clk = ~clk;

    // S-box table built by walking generator 3 and its inverse in parallel.
    task automatic build_sbox;
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int i = 0; i < 255; i++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic build_model(input logic [127:0] k);
        logic [31:0] w [4*(NR+1)];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 4*(NR+1); i++) begin
            t = w[i-1];
            if (i % 4 == 0)
                t = subword({t[23:0], t[31:24]}) ^ {rcon_tab[i/4-1], 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int j = 0; j <= NR; j++)
            exp_rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Accept k, then step through the NR expansion edges checking handshake
    // and done timing. With poke set, a different key is offered mid-expansion.
    task automatic load_key(input logic [127:0] k, input bit poke);
        build_model(k);
        key_in    = k;
        key_valid = 1'b1;
        tick;
        key_valid = 1'b0;
        key_in    = rand128();
        chk1("accept_busy", busy, 1'b1);
        chk1("accept_ready", key_ready, 1'b0);
        chk1("accept_kv", keys_valid, 1'b0);
        for (int e = 1; e <= NR; e++) begin
            if (poke && e == 3) begin
                key_valid = 1'b1;
                key_in    = ~k;
            end
            if (poke && e == 5) key_valid = 1'b0;
            tick;
            chk1($sformatf("done_e%0d", e), done, (e == NR));
            if (e < NR) chk1($sformatf("ready_e%0d", e), key_ready, 1'b0);
        end
        key_valid = 1'b0;
        chk1("end_kv", keys_valid, 1'b1);
        chk1("end_ready", key_ready, 1'b1);
        chk1("end_busy", busy, 1'b0);
        tick;
        chk1("done_pulse_end", done, 1'b0);
    endtask

    task automatic read_slot(input int i, input logic [127:0] expv, input string tag);
        rk_addr = 4'(i);
        tick;
        chk(tag, rk_out, expv);
    endtask

    task automatic read_all;
        for (int i = 0; i <= NR; i++)
            read_slot(i, exp_rk[i], $sformatf("slot%0d", i));
    endtask

    initial begin
        build_sbox();
        rst       = 1'b1;
        key_valid = 1'b0;
        key_in    = '0;
        rk_addr   = '0;
        tick;
        tick;
        chk1("rst_ready", key_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_kv", keys_valid, 1'b0);
        chk("rst_rk_out", rk_out, 128'h0);
        rst = 1'b0;
        tick;

        // FIPS-197 known-answer key
        load_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
        read_slot(1, 128'ha0fafe1788542cb123a339392a6c7605, "kat_slot1");
        read_slot(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "kat_slot10");
        read_all();

        // all-zero key
        load_key(128'h0, 1'b0);
        read_slot(1, 128'h62636363626363636263636362636363, "zero_slot1");
        read_slot(10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "zero_slot10");
        read_all();

        // key_valid offered during EXPAND must be ignored
        load_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
        read_slot(1, 128'ha0fafe1788542cb123a339392a6c7605, "poke_slot1");
        read_slot(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "poke_slot10");
        tick;
        chk1("poke_no_restart_busy", busy, 1'b0);

        // random keys
        for (int n = 0; n < 3; n++) begin
            load_key(rand128(), 1'b0);
            read_all();
        end

        // reset sampled at edge t0+5 aborts expansion
        key_in    = rand128();
        key_valid = 1'b1;
        tick;
        key_valid = 1'b0;
        for (int e = 1; e <= 4; e++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_ready", key_ready, 1'b1);
        chk1("abort_kv", keys_valid, 1'b0);
        chk1("abort_done", done, 1'b0);
        for (int e = 0; e < NR + 2; e++) begin
            tick;
            chk1($sformatf("abort_nodone_%0d", e), done, 1'b0);
        end
        chk1("abort_kv_idle", keys_valid, 1'b0);
        load_key(rand128(), 1'b0);
        read_all();

        // new key accepted in READY
        chk1("ready_kv_before", keys_valid, 1'b1);
        begin
            logic [127:0] k2;
            k2 = rand128();
            load_key(k2, 1'b0);
            read_slot(0, k2, "ready_slot0");
            read_all();
        end

        // out-of-range reads
        read_slot(11, 128'h0, "oor_11");
        read_slot(15, 128'h0, "oor_15");
        read_slot(10, exp_rk[10], "after_oor_10");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
